vec_mem_mover: RTL and testbench
================================

# vec_mem_mover

Command-driven initiator for the single-port block-RAM memory interface (addr0/ce0/d0/we0/q0, one-cycle read latency) used by the accelerator vectors. On each accepted command it either fills a contiguous, wrapping RAM region from an input stream or drains a region to an output stream. Both streams use valid/ready handshakes. It sits between the host/DMA stream side and one vector RAM instance.

## Interface
- DWIDTH, 32, data word width
- AWIDTH, 7, RAM address width
- MEM_SIZE, 128, RAM depth in words (≤ 2^AWIDTH)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = stream→RAM, 0 = RAM→stream
- cmd_base  in  AWIDTH  start address, < MEM_SIZE
- cmd_len  in  AWIDTH+1  word count, 0..MEM_SIZE
- s_data / s_valid / s_ready  in / in / out  DWIDTH / 1 / 1  write-data stream
- m_data / m_valid / m_ready  out / out / in  DWIDTH / 1 / 1  read-data stream
- done  out  1  one-cycle completion pulse
- addr0  out  AWIDTH  RAM address
- ce0  out  1  RAM enable
- we0  out  1  RAM write enable
- d0  out  DWIDTH  RAM write data
- q0  in  DWIDTH  RAM read data, valid the cycle after ce0 with we0=0

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch base, len, and direction; clear the counters. Go to DONE if len=0, else to WRITE or READ.
- Address of word i = base+i; if the sum ≥ MEM_SIZE, subtract MEM_SIZE. Compute in AWIDTH+1 bits.
- WRITE: s_ready=1.
  - ce0=we0=s_valid; d0=s_data; addr0=current address. These are combinational from the registers and s_*.
  - Each s_valid cycle increments the issue count.
  - After the len-th beat, go to DONE.
- READ: issue and capture path.
  - ce0=1, we0=0 when issued<len and credit allows. Credit rule: buffered + pending − pop < 2, where pending = a read issued in the previous cycle and pop = m_valid&m_ready this cycle.
  - q0 is captured into a 2-entry FIFO in the cycle after issue.
  - m_valid = FIFO non-empty; m_data = FIFO head, held stable while m_ready=0.
  - When the len-th beat is popped, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ce0 and we0 are 0 outside WRITE/READ; s_ready is 0 outside WRITE.
- Reset (any state, mid-transfer included): state→IDLE, counters and FIFO cleared.
  - ce0, we0, s_ready, m_valid, done = 0; addr0, d0, m_data = 0.
  - cmd_ready = 1 (IDLE).
  - A partial write already committed to RAM is not rolled back.

## Timing
- Command is accepted at edge E0.
- WRITE: first ce0/we0 possible in the cycle after E0. Sustains 1 word/cycle while s_valid=1.
- READ: first ce0 in the cycle after E0; first m_valid two cycles after that ce0.
  - With m_ready held high: 1 word/cycle, no bubbles.
  - With m_ready low: at most 2 words buffered, then ce0 stalls.
- done: cycle after the last write issue, or the cycle after the last m handshake. cmd_ready returns one cycle after done.
- len=0: done in the cycle after E0, no RAM access.
- len=MEM_SIZE: every address touched exactly once, wrapping through 0.

## Structure
- Shared package (vec_mem_pkg): state encodings, RAM read-latency constant (=1), FIFO depth constant (=2).
- One sub-module, mem_rd_skid: 2-entry synchronous FIFO with push/pop/count and async active-low reset. Used for the read capture buffer.
- Top: FSM, counters, address-wrap adder, credit logic.

## Test plan
- Write, base=0, len=4, s_data 0xA0..0xA3, s_valid constant → we0 on 4 consecutive cycles at addr 0..3, done one cycle after the last, cmd_ready next.
- Read back base=0, len=4, m_ready=1 → m_data 0xA0..0xA3 on 4 consecutive cycles, first m_valid two cycles after first ce0, done after the last beat.
- Read len=8 with m_ready toggling 1,0,0,1… → no lost or duplicated words, FIFO never >2, ce0 stalls while 2 are buffered, m_data stable when not accepted.
- Wrap: MEM_SIZE=128, base=126, len=4 write then read → addresses 126,127,0,1 both directions, data matches.
- len=0 command → done the cycle after acceptance, ce0 never asserted.
- rst_n pulsed low mid-READ with 1 word buffered → all outputs to reset values immediately; after release a new read len=2 returns the correct 2 words, nothing stale.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and constants for the vector RAM mover
//
// Purpose: FSM state encoding and the fixed RAM/FIFO timing constants used by
// vec_mem_mover and mem_rd_skid.

package vec_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Cycles from a read issue (ce0=1, we0=0) to q0 being valid.
    localparam int RD_LATENCY = 1;

    // Entries in the read capture buffer; also the read credit limit.
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mem_rd_skid.sv
// rtl/mem_rd_skid.sv - 2-entry synchronous FIFO capturing RAM read data
//
// Purpose: holds words returned on q0 until the output stream accepts them.
// Entry 0 is always the head, so the head value is a plain register output.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write one word (ignored when full and not popping)
//   pop          remove the head word (ignored when empty)
//   rdata        head word (0 after reset)
//   count        number of stored words, 0..2

module mem_rd_skid #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdata,
    output logic [1:0]        count
);

    logic [DWIDTH-1:0] e0_q;
    logic [DWIDTH-1:0] e1_q;
    logic [1:0]        count_q;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) e0_q <= wdata;
                    else                 e1_q <= wdata;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    e0_q    <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind the survivor.
                    if (count_q == 2'd1) begin
                        e0_q <= wdata;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata = e0_q;
    assign count = count_q;

endmodule

// File: rtl/vec_mem_mover.sv
// rtl/vec_mem_mover.sv - command-driven stream<->single-port RAM mover
//
// Purpose: per accepted command, fills a wrapping RAM region from the s_*
// stream (write) or drains a region to the m_* stream (read).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/ready/write/base/len command handshake and parameters
//   s_data/s_valid/s_ready         write-data stream into the RAM
//   m_data/m_valid/m_ready         read-data stream out of the RAM
//   done                           one-cycle completion pulse
//   addr0/ce0/we0/d0/q0            single-port RAM, one-cycle read latency

module vec_mem_mover
    import vec_mem_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 7,
    parameter int MEM_SIZE = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_base,
    input  logic [AWIDTH:0]   cmd_len,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              done,
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    output logic              we0,
    output logic [DWIDTH-1:0] d0,
    input  logic [DWIDTH-1:0] q0
);

    localparam logic [AWIDTH:0] MEM_SIZE_V = (AWIDTH+1)'(MEM_SIZE);
    localparam logic [AWIDTH:0] ONE        = (AWIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [AWIDTH-1:0]     base_q;
    logic [AWIDTH:0]       len_q;
    logic [AWIDTH:0]       issued_q;
    logic [AWIDTH:0]       popped_q;
    logic [RD_LATENCY-1:0] rd_pipe_q;

    logic [AWIDTH:0]       addr_sum;
    logic [AWIDTH:0]       addr_wrap;
    logic                  rd_issue;
    logic                  wr_beat;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [1:0]            fifo_count;
    logic [2:0]            credit_use;

    // One extra bit so base+i never overflows before the wrap subtract.
    assign addr_sum  = {1'b0, base_q} + issued_q;
    assign addr_wrap = (addr_sum >= MEM_SIZE_V) ? (addr_sum - MEM_SIZE_V) : addr_sum;

    // A read issued RD_LATENCY cycles ago has its data on q0 now.
    assign fifo_push = rd_pipe_q[RD_LATENCY-1];
    assign fifo_pop  = m_valid && m_ready;

    // Words that will occupy the FIFO after this edge if nothing new is issued:
    // already buffered, plus in flight from the RAM, minus the one leaving now.
    assign credit_use = {1'b0, fifo_count} + 3'($countones(rd_pipe_q)) - {2'b00, fifo_pop};

    assign rd_issue = (state_q == ST_READ) && (issued_q < len_q) &&
                      (credit_use < 3'(FIFO_DEPTH));
    assign wr_beat  = (state_q == ST_WRITE) && s_valid;

    mem_rd_skid #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (q0),
        .pop   (fifo_pop),
        .rdata (m_data),
        .count (fifo_count)
    );

    assign m_valid = (fifo_count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_pipe_q <= RD_LATENCY'({rd_pipe_q, rd_issue});
            if (state_q == ST_IDLE && cmd_valid) begin
                base_q   <= cmd_base;
                len_q    <= cmd_len;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (wr_beat || rd_issue) issued_q <= issued_q + ONE;
                if (fifo_pop)            popped_q <= popped_q + ONE;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        ce0       = 1'b0;
        we0       = 1'b0;
        addr0     = '0;
        d0        = '0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0)  state_d = ST_DONE;
                    else if (cmd_write) state_d = ST_WRITE;
                    else                state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                s_ready = 1'b1;
                ce0     = s_valid;
                we0     = s_valid;
                addr0   = addr_wrap[AWIDTH-1:0];
                d0      = s_data;
                if (s_valid && (issued_q + ONE == len_q)) state_d = ST_DONE;
            end
            ST_READ: begin
                ce0   = rd_issue;
                addr0 = addr_wrap[AWIDTH-1:0];
                if (fifo_pop && (popped_q + ONE == len_q)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vec_mem_mover.sv
// tb/tb_vec_mem_mover.sv - directed scoreboard bench for vec_mem_mover

module tb_vec_mem_mover;

    localparam int DW  = 32;
    localparam int AW  = 7;
    localparam int MEM = 128;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          done;
    logic [AW-1:0] addr0;
    logic          ce0;
    logic          we0;
    logic [DW-1:0] d0;
    logic [DW-1:0] q0;

    logic [DW-1:0] ram     [MEM];
    logic [DW-1:0] ref_mem [MEM];
    int            exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            total;
    int            bad;

    vec_mem_mover #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MEM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .done      (done),
        .addr0     (addr0),
        .ce0       (ce0),
        .we0       (we0),
        .d0        (d0),
        .q0        (q0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ce0) begin
            if (we0) ram[addr0] <= d0;
            else     q0 <= ram[addr0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce0"},       32'(ce0),       0);
        check({tag, "_we0"},       32'(we0),       0);
        check({tag, "_s_ready"},   32'(s_ready),   0);
        check({tag, "_m_valid"},   32'(m_valid),   0);
        check({tag, "_done"},      32'(done),      0);
        check({tag, "_addr0"},     32'(addr0),     0);
        check({tag, "_d0"},        d0,             0);
        check({tag, "_m_data"},    m_data,         0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    task automatic send_cmd(input bit wr, input int base, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        #1;
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_done_tail(input string tag);
        #1;
        check({tag, "_done"},      32'(done),      1);
        check({tag, "_busy"},      32'(cmd_ready), 0);
        @(negedge clk);
        #1;
        check({tag, "_done_off"},  32'(done),      0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    task automatic do_write(input int base, input int len, input int dbase, input bit gaps);
        int beats;
        int cyc;
        int wa;
        logic [DW-1:0] wd;
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back((base + i) % MEM);
            exp_data.push_back(DW'(dbase + i));
        end
        send_cmd(1'b1, base, len);
        beats = 0;
        cyc   = 0;
        while (beats < len && cyc < 1000) begin
            s_valid = !(gaps && (cyc % 3 == 2));
            s_data  = exp_data[0];
            #1;
            check("wr_s_ready", 32'(s_ready), 1);
            check("wr_ce0",     32'(ce0),     32'(s_valid));
            check("wr_we0",     32'(we0),     32'(s_valid));
            if (s_valid) begin
                wa = exp_addr.pop_front();
                wd = exp_data.pop_front();
                check("wr_addr0", 32'(addr0), wa);
                check("wr_d0",    d0,         wd);
                ref_mem[wa] = wd;
                beats++;
            end
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = '0;
        check("wr_beats", beats, len);
        check_done_tail("wr");
    endtask

    // mode 0: m_ready held high; mode 1: m_ready high one cycle in three.
    task automatic do_read(input int base, input int len, input int mode);
        int issued;
        int popped;
        int cyc;
        int outstanding;
        int prev_issue;
        int first_ce;
        int first_mv;
        bit pop;
        bit held_v;
        logic [DW-1:0] held;
        for (int i = 0; i < len; i++) exp_data.push_back(ref_mem[(base + i) % MEM]);
        send_cmd(1'b0, base, len);
        issued     = 0;
        popped     = 0;
        cyc        = 0;
        prev_issue = 0;
        first_ce   = -1;
        first_mv   = -1;
        held_v     = 1'b0;
        held       = '0;
        while (popped < len && cyc < 1000) begin
            m_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            outstanding = issued - popped;
            check("rd_m_valid", 32'(m_valid), 32'((outstanding - prev_issue) > 0));
            if (held_v && m_valid) check("rd_m_hold", m_data, held);
            pop = m_valid && m_ready;
            check("rd_ce0", 32'(ce0), 32'((issued < len) && (outstanding - int'(pop) < 2)));
            check("rd_fifo_bound", 32'(outstanding - int'(pop) + int'(ce0) <= 2), 1);
            if (ce0) begin
                check("rd_we0",   32'(we0),   0);
                check("rd_addr0", 32'(addr0), (base + issued) % MEM);
                if (first_ce < 0) first_ce = cyc;
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (pop) begin
                check("rd_data", m_data, exp_data.pop_front());
                popped++;
                held_v = 1'b0;
            end else if (m_valid) begin
                held   = m_data;
                held_v = 1'b1;
            end
            prev_issue = int'(ce0);
            issued     = issued + int'(ce0);
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        check("rd_beats",      popped,              len);
        check("rd_first_mv",   first_mv - first_ce, 2);
        check_done_tail("rd");
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        s_data    = '0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read-back, streaming at full rate.
        do_write(0, 4, 32'hA0, 1'b0);
        do_read(0, 4, 0);

        // Read with back-pressure: credit stall and stable m_data.
        do_write(8, 8, 32'hC0, 1'b0);
        do_read(8, 8, 1);

        // Region crossing the top of the RAM.
        do_write(126, 4, 32'hB0, 1'b0);
        do_read(126, 4, 0);

        // Zero-length command: done next cycle, no RAM access.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_base  = AW'(5);
        cmd_len   = '0;
        #1;
        check("len0_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        check("len0_done", 32'(done), 1);
        check("len0_ce0",  32'(ce0),  0);
        @(negedge clk);
        #1;
        check("len0_ce0_after", 32'(ce0),       0);
        check("len0_cmd_ready", 32'(cmd_ready), 1);

        // Reset mid-read with one word buffered and one in flight.
        send_cmd(1'b0, 0, 4);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("mid_m_valid", 32'(m_valid), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);
        do_read(0, 2, 0);

        // Whole RAM, starting mid-array, with write gaps and read back-pressure.
        do_write(5, MEM, 32'h1000, 1'b1);
        do_read(5, MEM, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
